// File: rtl/branch_compare_pipe.sv
// Branch-resolution pipeline: registers operands (S1), compares them with a
// log-depth comparator tree, decodes the RISC-V branch funct3 and registers
// the result (S2). It flags mispredictions against the fetch prediction and
// keeps a saturating mispredict counter.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   flush                   synchronous kill of both pipeline stages
//   in_valid/in_ready       operand beat handshake (in_ready is combinational)
//   in_a, in_b              rs1 / rs2 values
//   in_funct3, in_pred_taken, in_tag   branch kind, prediction, opaque tag
//   out_valid/out_ready     result beat handshake
//   out_taken, out_mispredict, out_illegal, out_slt, out_sltu, out_tag
//   cnt_clear               synchronous clear of mispredict_cnt
//   mispredict_cnt          saturating count of delivered mispredicts

// Magnitude comparator built as a binary tree over per-bit (eq, lt) pairs.
module comparatortree #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             lt,
    output logic             ltu
);

    localparam int unsigned LVLS = $clog2(WIDTH);

    // Pair i at each level merges the two children 2i+1 (upper) and 2i (lower):
    // the upper half decides unless it is equal, then the lower half decides.
    always_comb begin
        logic [WIDTH-1:0] e_v;
        logic [WIDTH-1:0] l_v;
        e_v = ~(a ^ b);
        l_v = ~a & b;
        for (int unsigned lvl = 0; lvl < LVLS; lvl++) begin
            for (int unsigned i = 0; i < WIDTH / 2; i++) begin
                if (i < (WIDTH >> (lvl + 1))) begin
                    // l before e: node 0 overwrites its own lower child
                    l_v[i] = l_v[2*i+1] | (e_v[2*i+1] & l_v[2*i]);
                    e_v[i] = e_v[2*i+1] & e_v[2*i];
                end
            end
        end
        eq  = e_v[0];
        ltu = l_v[0];
        // Differing sign bits: the negative operand is the smaller one.
        lt  = (a[WIDTH-1] ^ b[WIDTH-1]) ? a[WIDTH-1] : l_v[0];
    end

endmodule

module branch_compare_pipe #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned TAGW  = 6,
    parameter int unsigned CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_funct3,
    input  logic             in_pred_taken,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_mispredict,
    output logic             out_illegal,
    output logic             out_slt,
    output logic             out_sltu,
    output logic [TAGW-1:0]  out_tag,
    input  logic             cnt_clear,
    output logic [CNTW-1:0]  mispredict_cnt
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_funct3;
    logic             s1_pred;
    logic [TAGW-1:0]  s1_tag;

    logic cmp_eq;
    logic cmp_lt;
    logic cmp_ltu;

    logic taken_c;
    logic illegal_c;
    logic mispredict_c;

    logic in_fire;
    logic s2_load;
    logic out_fire;

    // S2 is the output register, so out_valid doubles as s2_valid.
    assign in_ready = !s1_valid || !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign out_fire = out_valid && out_ready;

    comparatortree #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .a   (s1_a),
        .b   (s1_b),
        .eq  (cmp_eq),
        .lt  (cmp_lt),
        .ltu (cmp_ltu)
    );

    // funct3 decode; 010/011 are not branches and never count as mispredicts.
    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        unique case (s1_funct3)
            3'b000:  taken_c = cmp_eq;
            3'b001:  taken_c = !cmp_eq;
            3'b100:  taken_c = cmp_lt;
            3'b101:  taken_c = !cmp_lt;
            3'b110:  taken_c = cmp_ltu;
            3'b111:  taken_c = !cmp_ltu;
            default: illegal_c = 1'b1;
        endcase
        mispredict_c = !illegal_c && (taken_c != s1_pred);
    end

    // S1 operand stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_funct3 <= '0;
            s1_pred   <= 1'b0;
            s1_tag    <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (in_fire) begin
                s1_valid <= 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (in_fire && !flush) begin
                s1_a      <= in_a;
                s1_b      <= in_b;
                s1_funct3 <= in_funct3;
                s1_pred   <= in_pred_taken;
                s1_tag    <= in_tag;
            end
        end
    end

    // S2 result stage; payload holds while stalled or invalid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid      <= 1'b0;
            out_taken      <= 1'b0;
            out_mispredict <= 1'b0;
            out_illegal    <= 1'b0;
            out_slt        <= 1'b0;
            out_sltu       <= 1'b0;
            out_tag        <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (s2_load) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (s2_load && !flush) begin
                out_taken      <= taken_c;
                out_mispredict <= mispredict_c;
                out_illegal    <= illegal_c;
                out_slt        <= cmp_lt;
                out_sltu       <= cmp_ltu;
                out_tag        <= s1_tag;
            end
        end
    end

    // Saturating mispredict counter; a transfer in a flush cycle still counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mispredict_cnt <= '0;
        end else if (cnt_clear) begin
            mispredict_cnt <= '0;
        end else if (out_fire && out_mispredict && (mispredict_cnt != '1)) begin
            mispredict_cnt <= mispredict_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_branch_compare_pipe.sv
// Bench for branch_compare_pipe: directed scenarios with literal expectations
// followed by randomized traffic, all checked against a queue-based model.
module tb_branch_compare_pipe;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned TAGW  = 6;
    localparam int unsigned CNTW  = 4;
    localparam int unsigned CMAX  = (1 << CNTW) - 1;

    logic             clk;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_funct3;
    logic             in_pred_taken;
    logic [TAGW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic             out_mispredict;
    logic             out_illegal;
    logic             out_slt;
    logic             out_sltu;
    logic [TAGW-1:0]  out_tag;
    logic             cnt_clear;
    logic [CNTW-1:0]  mispredict_cnt;

    branch_compare_pipe #(
        .WIDTH(WIDTH),
        .TAGW (TAGW),
        .CNTW (CNTW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_funct3     (in_funct3),
        .in_pred_taken (in_pred_taken),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_taken     (out_taken),
        .out_mispredict(out_mispredict),
        .out_illegal   (out_illegal),
        .out_slt       (out_slt),
        .out_sltu      (out_sltu),
        .out_tag       (out_tag),
        .cnt_clear     (cnt_clear),
        .mispredict_cnt(mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TAGW-1:0] tag;
        logic            taken;
        logic            mis;
        logic            ill;
        logic            slt;
        logic            sltu;
        int              acc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int unsigned mcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural meaning of one branch beat.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [2:0] f3, input logic pred,
                                   input logic [TAGW-1:0] tag, input int acc);
        exp_t e;
        logic eq;
        eq     = (a == b);
        e.slt  = ($signed(a) < $signed(b));
        e.sltu = (a < b);
        e.ill  = 1'b0;
        case (f3)
            3'd0:    e.taken = eq;
            3'd1:    e.taken = !eq;
            3'd4:    e.taken = e.slt;
            3'd5:    e.taken = !e.slt;
            3'd6:    e.taken = e.sltu;
            3'd7:    e.taken = !e.sltu;
            default: begin e.taken = 1'b0; e.ill = 1'b1; end
        endcase
        e.mis = !e.ill && (e.taken != pred);
        e.tag = tag;
        e.acc = acc;
        return e;
    endfunction

    // Model: in-flight beats in order; the oldest becomes visible one edge after
    // it was accepted; at most two beats are held.
    always @(negedge clk) begin
        logic mv;
        logic mr;
        logic xfer;
        logic hmis;
        if (!reset_n) begin
            q.delete();
            mcnt = 0;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_cnt", 64'(mispredict_cnt), 64'd0);
        end else begin
            mv   = (q.size() > 0) && (q[0].acc < cyc);
            mr   = (q.size() < 2) || out_ready;
            xfer = mv && out_ready;
            hmis = 1'b0;
            chk("out_valid", 64'(out_valid), 64'(mv));
            chk("in_ready", 64'(in_ready), 64'(mr));
            chk("cnt", 64'(mispredict_cnt), 64'(mcnt));
            if (xfer) begin
                chk("tag", 64'(out_tag), 64'(q[0].tag));
                chk("taken", 64'(out_taken), 64'(q[0].taken));
                chk("mispredict", 64'(out_mispredict), 64'(q[0].mis));
                chk("illegal", 64'(out_illegal), 64'(q[0].ill));
                chk("slt", 64'(out_slt), 64'(q[0].slt));
                chk("sltu", 64'(out_sltu), 64'(q[0].sltu));
                hmis = q[0].mis;
                void'(q.pop_front());
            end
            if (cnt_clear) mcnt = 0;
            else if (hmis && mcnt < CMAX) mcnt++;
            if (flush) q.delete();
            else if (in_valid && mr)
                q.push_back(model(in_a, in_b, in_funct3, in_pred_taken, in_tag, cyc + 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] f3, input logic pred, input logic [TAGW-1:0] tag);
        in_a          = a;
        in_b          = b;
        in_funct3     = f3;
        in_pred_taken = pred;
        in_tag        = tag;
        in_valid      = 1'b1;
    endtask

    // Offer one beat, then idle; returns once the result is on the outputs.
    task automatic single(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2:0] f3, input logic pred, input logic [TAGW-1:0] tag);
        offer(a, b, f3, pred, tag);
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        int          k;
        logic        acc_now;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [2:0]  f3r;

        reset_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_funct3 = '0;
        in_pred_taken = 1'b0;
        in_tag = '0;
        out_ready = 1'b1;
        cnt_clear = 1'b0;

        repeat (3) tick();
        chk("reset_out_taken", 64'(out_taken), 64'd0);
        chk("reset_out_tag", 64'(out_tag), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        reset_n = 1'b1;
        tick();

        // Equal operands, BEQ predicted not-taken.
        single(64'd5, 64'd5, 3'b000, 1'b0, 6'd1);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_taken", 64'(out_taken), 64'd1);
        chk("t1_mis", 64'(out_mispredict), 64'd1);
        chk("t1_tag", 64'(out_tag), 64'd1);
        tick();
        chk("t1_cnt", 64'(mispredict_cnt), 64'd1);

        // -1 vs 1: signed less, unsigned greater.
        single(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b100, 1'b1, 6'd2);
        chk("t2_blt_taken", 64'(out_taken), 64'd1);
        chk("t2_slt", 64'(out_slt), 64'd1);
        chk("t2_sltu", 64'(out_sltu), 64'd0);
        chk("t2_blt_mis", 64'(out_mispredict), 64'd0);
        tick();
        single(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b110, 1'b0, 6'd3);
        chk("t2_bltu_taken", 64'(out_taken), 64'd0);
        chk("t2_bltu_slt", 64'(out_slt), 64'd1);
        tick();

        // Illegal funct3 never mispredicts.
        single(64'd7, 64'd7, 3'b010, 1'b1, 6'd4);
        chk("t4_illegal", 64'(out_illegal), 64'd1);
        chk("t4_taken", 64'(out_taken), 64'd0);
        chk("t4_mis", 64'(out_mispredict), 64'd0);
        tick();
        chk("t4_cnt", 64'(mispredict_cnt), 64'd1);

        // Eight back-to-back beats at full throughput.
        for (int i = 0; i < 8; i++) begin
            offer(64'(i * 3), 64'(9 - i), 3'(($urandom_range(0, 2) * 2) | (i & 1)) | 3'b100,
                  1'($urandom), 6'(10 + i));
            tick();
            if (i >= 1) begin
                chk("t3_stream_valid", 64'(out_valid), 64'd1);
                chk("t3_stream_tag", 64'(out_tag), 64'(10 + i - 1));
            end
        end
        in_valid = 1'b0;
        tick();
        chk("t3_last_tag", 64'(out_tag), 64'd17);
        tick();
        chk("t3_drained", 64'(out_valid), 64'd0);

        // Output stall: only two beats can be held.
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            offer(64'(c), 64'(c), 3'b001, 1'b0, 6'(20 + k));
            if (c == 2) chk("t3_stall_ready", 64'(in_ready), 64'd0);
            acc_now = in_ready;
            tick();
            if (acc_now) k++;
        end
        chk("t3_held_beats", 64'(k), 64'd2);
        in_valid = 1'b0;
        chk("t3_stall_tag", 64'(out_tag), 64'd20);
        out_ready = 1'b1;
        tick();
        chk("t3_second_tag", 64'(out_tag), 64'd21);
        tick();
        chk("t3_stall_drained", 64'(out_valid), 64'd0);

        // Flush with both stages full and a third beat offered.
        out_ready = 1'b0;
        offer(64'd1, 64'd1, 3'b000, 1'b0, 6'd30);
        tick();
        offer(64'd1, 64'd1, 3'b000, 1'b0, 6'd31);
        tick();
        offer(64'd1, 64'd1, 3'b000, 1'b0, 6'd32);
        flush = 1'b1;
        chk("t5_pre_valid", 64'(out_valid), 64'd1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5_post_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t5_no_result", 64'(out_valid), 64'd0);
        end

        // Saturation and clear-over-increment priority.
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        chk("t6_cleared", 64'(mispredict_cnt), 64'd0);
        for (int i = 0; i < 16; i++) begin
            offer(64'd9, 64'd9, 3'b000, 1'b0, 6'(i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("t6_saturated", 64'(mispredict_cnt), 64'd15);
        single(64'd9, 64'd9, 3'b000, 1'b0, 6'd40);
        tick();
        chk("t6_stays", 64'(mispredict_cnt), 64'd15);
        single(64'd9, 64'd9, 3'b000, 1'b0, 6'd41);
        chk("t6_mis_present", 64'(out_mispredict), 64'd1);
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        chk("t6_clear_priority", 64'(mispredict_cnt), 64'd0);

        // Randomized traffic with a mid-stream reset.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) reset_n = 1'b0;
            if (c == 1502) reset_n = 1'b1;
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra + 64'd1;
                2:       rb = ra ^ 64'h8000_0000_0000_0000;
                default: rb = {$urandom, $urandom};
            endcase
            f3r = 3'($urandom_range(0, 7));
            in_a          = ra;
            in_b          = rb;
            in_funct3     = f3r;
            in_pred_taken = 1'($urandom);
            in_tag        = TAGW'($urandom);
            in_valid      = ($urandom_range(0, 3) != 0);
            out_ready     = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 63) == 0);
            cnt_clear     = ($urandom_range(0, 127) == 0);
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        cnt_clear = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
